// File: rtl/mux_4x1_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1_if
// Description : Bundle of the data, select and result signals of the
//               registered 4-to-1 multiplexer.
//               master : drives i0..i3, s0, s1 (and en), observes out
//               slave  : the multiplexer itself; samples inputs, drives out
//               Optional feature macro: MUX_4X1_HOLD_EN (adds en).
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_4x1_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic [WIDTH-1:0] i2;
   logic [WIDTH-1:0] i3;
   logic             s0;
   logic             s1;
`ifdef MUX_4X1_HOLD_EN
   logic             en;
`endif
   logic [WIDTH-1:0] out;

`ifdef MUX_4X1_HOLD_EN
   modport master (output i0, i1, i2, i3, s0, s1, en, input out);
   modport slave  (input  i0, i1, i2, i3, s0, s1, en, output out);
`else
   modport master (output i0, i1, i2, i3, s0, s1, input out);
   modport slave  (input  i0, i1, i2, i3, s0, s1, output out);
`endif
endinterface
`default_nettype wire

// File: rtl/mux_4x1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1
// Description : Registered 4-to-1 multiplexer. The 2-bit select {s1,s0}
//               steers one of i0..i3 onto a register that drives out, with
//               one cycle of latency. Reset is asynchronous, active-high,
//               and clears out to zero.
// Ports       : clk - rising-edge clock
//               rst - asynchronous active-high reset
//               bus - mux_4x1_if.slave (i0..i3, s0, s1, [en], out)
// Config      : MUX_4X1_HOLD_EN defined -> en gates the capture (out holds
//               while en=0; reset still wins). Undefined -> capture on
//               every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4x1 #(
   parameter int WIDTH = 1
) (
   input  wire logic   clk,
   input  wire logic   rst,
   mux_4x1_if.slave    bus
);

   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] out_reg;
   logic             capture;

   // Full-width selection. An unknown select bit matches none of the four
   // items, so simulation propagates X instead of a bit-blend of sources;
   // synthesis is free to treat that path as don't-care.
   always_comb begin
      sel_data = 'x;
      case ({bus.s1, bus.s0})
         2'b00: sel_data = bus.i0;
         2'b01: sel_data = bus.i1;
         2'b10: sel_data = bus.i2;
         2'b11: sel_data = bus.i3;
         default: sel_data = 'x;
      endcase
   end

`ifdef MUX_4X1_HOLD_EN
   assign capture = bus.en;
`else
   assign capture = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_reg <= '0;
      end else if (capture) begin
         out_reg <= sel_data;
      end
   end

   assign bus.out = out_reg;

endmodule
`default_nettype wire

// File: tb/tb_mux_4x1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4x1
// Description : Directed self-checking bench for mux_4x1. One instance at
//               WIDTH=1 (one-hot sweep, isolation, resets) and one at
//               WIDTH=8 (wide data, optional hold-enable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4x1;

   logic clk;
   logic rst;
   int   passed;
   int   total;

   mux_4x1_if #(.WIDTH(1)) bus_a ();
   mux_4x1_if #(.WIDTH(8)) bus_b ();

   mux_4x1 #(.WIDTH(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   mux_4x1 #(.WIDTH(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance past the next rising edge, landing 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic [1:0] sel, input logic [3:0] d);
      {bus_a.s1, bus_a.s0} = sel;
      bus_a.i0 = d[0];
      bus_a.i1 = d[1];
      bus_a.i2 = d[2];
      bus_a.i3 = d[3];
   endtask

   initial begin
      logic [7:0] wide_data [4];
      logic [3:0] onehot;
      passed = 0;
      total  = 0;

      rst = 1'b1;
      set_a(2'b00, 4'b0001);
      {bus_b.s1, bus_b.s0} = 2'b00;
      bus_b.i0 = 8'hA5;
      bus_b.i1 = 8'h3C;
      bus_b.i2 = 8'hFF;
      bus_b.i3 = 8'h00;
`ifdef MUX_4X1_HOLD_EN
      bus_a.en = 1'b1;
      bus_b.en = 1'b1;
`endif

      // Reset held across edges with i0=1 selected.
      step();
      step();
      check("rst_hold_a", {7'b0, bus_a.out}, 8'h00);
      check("rst_hold_b", bus_b.out, 8'h00);
      rst = 1'b0;
      #1;
      check("rst_release_noedge", {7'b0, bus_a.out}, 8'h00);
      step();
      check("rst_first_capture", {7'b0, bus_a.out}, 8'h01);

      // One-hot sweep: selected source is 1 -> out=1.
      for (int k = 0; k < 4; k++) begin
         onehot = 4'b0001 << k;
         set_a(k[1:0], onehot);
         step();
         check($sformatf("onehot_sel%0d", k), {7'b0, bus_a.out}, 8'h01);
      end
      // Complementary sweep: everything but the selected source is 1 -> out=0.
      for (int k = 0; k < 4; k++) begin
         onehot = 4'b0001 << k;
         set_a(k[1:0], ~onehot);
         step();
         check($sformatf("inverse_sel%0d", k), {7'b0, bus_a.out}, 8'h00);
      end

      // Isolation: sel=10, i2=0, other sources toggling each cycle.
      for (int k = 0; k < 4; k++) begin
         set_a(2'b10, (k % 2 == 0) ? 4'b1011 : 4'b0000);
         step();
         check($sformatf("isolation_%0d", k), {7'b0, bus_a.out}, 8'h00);
      end

      // Mid-stream asynchronous reset pulse between edges.
      set_a(2'b11, 4'b1000);
      step();
      check("stream_sel3", {7'b0, bus_a.out}, 8'h01);
      #2 rst = 1'b1;
      #1;
      check("async_clear_a", {7'b0, bus_a.out}, 8'h00);
      check("async_clear_b", bus_b.out, 8'h00);
      #1 rst = 1'b0;
      #1;
      check("after_release_noedge", {7'b0, bus_a.out}, 8'h00);
      step();
      check("stream_recover", {7'b0, bus_a.out}, 8'h01);

      // Wide data sweep.
      wide_data[0] = 8'hA5;
      wide_data[1] = 8'h3C;
      wide_data[2] = 8'hFF;
      wide_data[3] = 8'h00;
      for (int k = 0; k < 4; k++) begin
         {bus_b.s1, bus_b.s0} = k[1:0];
         step();
         check($sformatf("wide_sel%0d", k), bus_b.out, wide_data[k]);
      end

`ifdef MUX_4X1_HOLD_EN
      // Hold-enable: capture 0xA5, then hold it while en=0 with sel=01.
      {bus_b.s1, bus_b.s0} = 2'b00;
      bus_b.en = 1'b1;
      step();
      check("hold_load", bus_b.out, 8'hA5);
      bus_b.en = 1'b0;
      {bus_b.s1, bus_b.s0} = 2'b01;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("hold_%0d", k), bus_b.out, 8'hA5);
      end
      bus_b.en = 1'b1;
      step();
      check("hold_release", bus_b.out, 8'h3C);
      // Reset overrides en=0.
      bus_b.en = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("hold_rst_override", bus_b.out, 8'h00);
      rst = 1'b0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
